// File: rtl/dma_engine_2a03_pkg.sv
// Shared types and constants for the 2A03 sprite/sample DMA engine.
package dma_engine_2a03_pkg;

    typedef enum logic [2:0] {
        DMA_ST_IDLE  = 3'd0,
        DMA_ST_HALT  = 3'd1,
        DMA_ST_ALIGN = 3'd2,
        DMA_ST_GET   = 3'd3,
        DMA_ST_PUT   = 3'd4,
        DMA_ST_DMC   = 3'd5
    } dma_state_t;

    localparam logic [15:0] DMA_TRIGGER_ADDR_DEF = 16'h4014;
    localparam logic [15:0] DMA_DST_ADDR_DEF     = 16'h2004;

    localparam logic DMA_CYC_GET = 1'b0;
    localparam logic DMA_CYC_PUT = 1'b1;

endpackage

// File: rtl/dma_engine_2a03_parity.sv
// Free-running get/put cycle parity flop; reset starts on a get cycle.
module dma_cycle_parity
    import dma_engine_2a03_pkg::*;
(
    input  logic clock,
    input  logic nreset,
    output logic parity
);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) parity <= DMA_CYC_GET;
        else         parity <= ~parity;
    end

endmodule

// File: rtl/dma_engine_2a03.sv
// Sprite/sample DMA beside cpu_2a03: snoops trigger writes, halts the CPU, copies one page.
// Optional sample-fetch channel enabled by defining DMA_DMC_CHANNEL_EN.
module dma_engine_2a03
    import dma_engine_2a03_pkg::*;
#(
    parameter int unsigned XFER_LEN     = 256,
    parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR_DEF,
    parameter logic [15:0] DST_ADDR     = DMA_DST_ADDR_DEF
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_rw,
    input  logic [7:0]  data_in,
`ifdef DMA_DMC_CHANNEL_EN
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
`endif
    output logic        done
);

    localparam logic [8:0] LAST_COUNT = 9'(XFER_LEN - 1);

    dma_state_t  state, state_n;
    logic        parity;
    logic        trigger;
    logic        get_entry;
    logic [8:0]  count, count_n;
    logic [7:0]  page, page_n;
    logic        cpu_halt_n, dma_active_n, dma_rw_n, done_n;
    logic [15:0] dma_addr_n;
    logic [7:0]  dma_data_out_n;
`ifdef DMA_DMC_CHANNEL_EN
    logic        copy_run, copy_run_n;
    logic        dmc_dummy, dmc_dummy_n;
    logic        dmc_ack_n;
    logic [7:0]  dmc_data_n;
`endif

    dma_cycle_parity u_parity (
        .clock  (clock),
        .nreset (nreset),
        .parity (parity)
    );

    assign trigger = !cpu_rw && (cpu_addr == TRIGGER_ADDR);

    always_comb begin
        state_n        = state;
        count_n        = count;
        page_n         = page;
        dma_data_out_n = dma_data_out;
        done_n         = 1'b0;
        get_entry      = 1'b0;
`ifdef DMA_DMC_CHANNEL_EN
        copy_run_n     = copy_run;
        dmc_dummy_n    = 1'b0;
        dmc_ack_n      = 1'b0;
        dmc_data_n     = dmc_data;
`endif
        case (state)
            DMA_ST_IDLE: begin
                if (trigger) begin
                    page_n  = cpu_data_out;
                    count_n = '0;
                    state_n = DMA_ST_HALT;
`ifdef DMA_DMC_CHANNEL_EN
                    copy_run_n = 1'b1;
                end else if (dmc_req) begin
                    state_n = DMA_ST_HALT;
`endif
                end
            end
            DMA_ST_HALT: begin
                if (cpu_rw) begin
                    if (parity == DMA_CYC_PUT) state_n = DMA_ST_ALIGN;
                    else                       get_entry = 1'b1;
                end
            end
            DMA_ST_ALIGN: begin
`ifdef DMA_DMC_CHANNEL_EN
                // The dummy cycle after a fetch resumes without re-sampling dmc_req,
                // giving the requester the ack cycle to drop its level request.
                if (dmc_dummy) state_n = copy_run ? DMA_ST_GET : DMA_ST_IDLE;
                else           get_entry = 1'b1;
`else
                get_entry = 1'b1;
`endif
            end
            DMA_ST_GET: begin
                dma_data_out_n = data_in;
                state_n        = DMA_ST_PUT;
            end
            DMA_ST_PUT: begin
                if (count == LAST_COUNT) begin
                    count_n = '0;
                    done_n  = 1'b1;
                    state_n = DMA_ST_IDLE;
`ifdef DMA_DMC_CHANNEL_EN
                    copy_run_n = 1'b0;
`endif
                end else begin
                    count_n   = count + 9'd1;
                    get_entry = 1'b1;
                end
            end
`ifdef DMA_DMC_CHANNEL_EN
            DMA_ST_DMC: begin
                dmc_data_n  = data_in;
                dmc_ack_n   = 1'b1;
                dmc_dummy_n = 1'b1;
                state_n     = DMA_ST_ALIGN;
            end
`endif
            default: state_n = DMA_ST_IDLE;
        endcase

        if (get_entry) begin
`ifdef DMA_DMC_CHANNEL_EN
            if (dmc_req)       state_n = DMA_ST_DMC;
            else if (copy_run) state_n = DMA_ST_GET;
            else               state_n = DMA_ST_IDLE;
`else
            state_n = DMA_ST_GET;
`endif
        end

        // Bus outputs are registered from the next state so they change only on edges.
        cpu_halt_n   = (state_n != DMA_ST_IDLE);
        dma_active_n = 1'b0;
        dma_rw_n     = 1'b1;
        dma_addr_n   = '0;
        case (state_n)
            DMA_ST_GET: begin
                dma_active_n = 1'b1;
                dma_addr_n   = {page_n, count_n[7:0]};
            end
            DMA_ST_PUT: begin
                dma_active_n = 1'b1;
                dma_rw_n     = 1'b0;
                dma_addr_n   = DST_ADDR;
            end
`ifdef DMA_DMC_CHANNEL_EN
            DMA_ST_DMC: begin
                dma_active_n = 1'b1;
                dma_addr_n   = dmc_addr;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= DMA_ST_IDLE;
            count        <= '0;
            page         <= '0;
            cpu_halt     <= 1'b0;
            dma_active   <= 1'b0;
            dma_addr     <= '0;
            dma_data_out <= '0;
            dma_rw       <= 1'b1;
            done         <= 1'b0;
`ifdef DMA_DMC_CHANNEL_EN
            copy_run     <= 1'b0;
            dmc_dummy    <= 1'b0;
            dmc_ack      <= 1'b0;
            dmc_data     <= '0;
`endif
        end else begin
            state        <= state_n;
            count        <= count_n;
            page         <= page_n;
            cpu_halt     <= cpu_halt_n;
            dma_active   <= dma_active_n;
            dma_addr     <= dma_addr_n;
            dma_data_out <= dma_data_out_n;
            dma_rw       <= dma_rw_n;
            done         <= done_n;
`ifdef DMA_DMC_CHANNEL_EN
            copy_run     <= copy_run_n;
            dmc_dummy    <= dmc_dummy_n;
            dmc_ack      <= dmc_ack_n;
            dmc_data     <= dmc_data_n;
`endif
        end
    end

endmodule
